// File: rtl/fm_sb_pkg.sv
// Shared types and constants for the fast-monitoring spy-buffer sequencer.
// Holds the playback-mode encodings and the sequencer state encoding.
package fm_sb_pkg;

  localparam int unsigned PB_MODE_WIDTH = 2;

  typedef enum logic [PB_MODE_WIDTH-1:0] {
    PBM_STOP    = 2'b00,
    PBM_CAPTURE = 2'b01,
    PBM_ONCE    = 2'b10,
    PBM_LOOP    = 2'b11
  } pb_mode_t;

  localparam logic [PB_MODE_WIDTH-1:0] MODE_STOP    = 2'b00;
  localparam logic [PB_MODE_WIDTH-1:0] MODE_CAPTURE = 2'b01;
  localparam logic [PB_MODE_WIDTH-1:0] MODE_ONCE    = 2'b10;
  localparam logic [PB_MODE_WIDTH-1:0] MODE_LOOP    = 2'b11;

  typedef logic [2:0] sb_seq_state_t;

  localparam sb_seq_state_t ST_IDLE      = 3'd0;
  localparam sb_seq_state_t ST_CAPTURE   = 3'd1;
  localparam sb_seq_state_t ST_POST_TRIG = 3'd2;
  localparam sb_seq_state_t ST_FROZEN    = 3'd3;
  localparam sb_seq_state_t ST_PLAYBACK  = 3'd4;
  localparam sb_seq_state_t ST_PB_DONE   = 3'd5;

endpackage

// File: rtl/fm_sb_seq_if.sv
// Spy-buffer memory port bundle (one write port, one registered read port).
//   master : sequencer side (drives we/waddr/wdata/re/raddr, receives rdata)
//   slave  : memory side
interface fm_sb_seq_if #(
  parameter int unsigned SB_DW  = 64,
  parameter int unsigned ADDR_W = 10
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [SB_DW-1:0]  mem_wdata;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_raddr;
  logic [SB_DW-1:0]  mem_rdata;

  modport master (
    output mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
    input  mem_rdata
  );

  modport slave (
    input  mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
    output mem_rdata
  );
endinterface

// File: rtl/fm_sb_rd_seq.sv
// Read-pointer generator for spy-buffer playback.
//   start       : pulse on playback entry; clears pointer, samples len
//   run         : high while playing back; issues one read per cycle
//   loop        : wrap to 0 after len instead of stopping
//   len         : last address to read (length minus 1)
//   mem_re/mem_raddr : memory read request
//   mem_rdata   : registered memory data, 1-cycle latency
//   pb_vld/pb_data   : read data aligned with its valid
//   last_issued : the read at len is being issued in a non-looping run
module fm_sb_rd_seq
  import fm_sb_pkg::*;
#(
  parameter int unsigned SB_DW  = 64,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              run,
  input  logic              loop,
  input  logic [ADDR_W-1:0] len,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [SB_DW-1:0]  mem_rdata,
  output logic              pb_vld,
  output logic [SB_DW-1:0]  pb_data,
  output logic              last_issued
);

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] len_q;
  logic              vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      len_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      // Valid trails the request by the memory's one cycle of read latency,
      // so a read issued in the cycle playback is stopped still shows up.
      vld_q <= run;
      if (start) begin
        rd_ptr <= '0;
        len_q  <= len;
      end else if (run) begin
        if (rd_ptr == len_q) rd_ptr <= '0;
        else                 rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign mem_re      = run;
  assign mem_raddr   = rd_ptr;
  assign pb_vld      = vld_q;
  assign pb_data     = vld_q ? mem_rdata : '0;
  assign last_issued = run && !loop && (rd_ptr == len_q);

endmodule

// File: rtl/fm_sb_seq.sv
// Per-spy-buffer sequencer: circular capture of a monitored bus, freeze after
// a programmable post-trigger depth, and once/looped playback of stored words.
//   clk, rst          : clock, asynchronous active-high reset
//   pb_mode           : 00 STOP, 01 CAPTURE, 10 PB_ONCE, 11 PB_LOOP
//   freeze_req/clr    : trigger pulse / release-from-frozen pulse
//   post_trig         : words written after the trigger word
//   pb_len            : playback length minus 1
//   mon_data/mon_vld  : monitored bus
//   mem               : spy-buffer memory port bundle (master side)
//   pb_data/vld/done  : playback stream and PB_ONCE completion pulse
//   frozen, wrapped, last_waddr : capture status
//   capture_cnt       : words captured; built only with FM_SB_CAPTURE_CNT_EN
module fm_sb_seq
  import fm_sb_pkg::*;
#(
  parameter int unsigned SB_DW  = 64,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PB_MODE_WIDTH-1:0] pb_mode,
  input  logic                     freeze_req,
  input  logic                     freeze_clr,
  input  logic [ADDR_W-1:0]        post_trig,
  input  logic [ADDR_W-1:0]        pb_len,
  input  logic [SB_DW-1:0]         mon_data,
  input  logic                     mon_vld,
  fm_sb_seq_if.master              mem,
  output logic [SB_DW-1:0]         pb_data,
  output logic                     pb_vld,
  output logic                     pb_done,
  output logic                     frozen,
  output logic                     wrapped,
  output logic [ADDR_W-1:0]        last_waddr,
  output logic [CNT_W-1:0]         capture_cnt
);

  sb_seq_state_t     state, nxt;
  pb_mode_t          mode_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] trig_cnt;
  logic              wrapped_q;
  logic [ADDR_W-1:0] last_q;
  logic              pb_done_q;
  logic              capturing;
  logic              wr_fire;
  logic              cap_entry;
  logic              rd_start;
  logic              last_issued;

  assign capturing = (state == ST_CAPTURE) || (state == ST_POST_TRIG);
  assign wr_fire   = capturing && mon_vld;

  always_comb begin
    nxt = state;
    if (pb_mode == MODE_STOP) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:
          nxt = (pb_mode == MODE_CAPTURE) ? ST_CAPTURE : ST_PLAYBACK;
        ST_CAPTURE:
          if (pb_mode != MODE_CAPTURE) nxt = ST_IDLE;
          else if (freeze_req)         nxt = (post_trig == '0) ? ST_FROZEN : ST_POST_TRIG;
        ST_POST_TRIG:
          if (pb_mode != MODE_CAPTURE)       nxt = ST_IDLE;
          else if (wr_fire && trig_cnt == 1) nxt = ST_FROZEN;
        ST_FROZEN:
          if (freeze_clr) nxt = ST_IDLE;
        ST_PLAYBACK:
          // A switch between ONCE and LOOP also counts as a mode change.
          if (pb_mode != mode_q) nxt = ST_IDLE;
          else if (last_issued)  nxt = ST_PB_DONE;
        ST_PB_DONE:
          nxt = ST_PB_DONE;
        default:
          nxt = ST_IDLE;
      endcase
    end
  end

  assign cap_entry = (state == ST_IDLE) && (nxt == ST_CAPTURE);
  assign rd_start  = (state == ST_IDLE) && (nxt == ST_PLAYBACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= PBM_STOP;
      wr_ptr    <= '0;
      trig_cnt  <= '0;
      wrapped_q <= 1'b0;
      last_q    <= '0;
      pb_done_q <= 1'b0;
    end else begin
      state     <= nxt;
      pb_done_q <= (state == ST_PLAYBACK) && (nxt == ST_PB_DONE);
      if (state == ST_IDLE) mode_q <= pb_mode_t'(pb_mode);

      if (cap_entry) begin
        wr_ptr    <= '0;
        wrapped_q <= 1'b0;
      end else if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        last_q <= wr_ptr;
        if (wr_ptr == '1) wrapped_q <= 1'b1;
      end

      if (state == ST_CAPTURE && nxt == ST_POST_TRIG) trig_cnt <= post_trig;
      else if (state == ST_POST_TRIG && wr_fire)       trig_cnt <= trig_cnt - 1'b1;
    end
  end

  fm_sb_rd_seq #(
    .SB_DW  (SB_DW),
    .ADDR_W (ADDR_W)
  ) u_rd_seq (
    .clk         (clk),
    .rst         (rst),
    .start       (rd_start),
    .run         (state == ST_PLAYBACK),
    .loop        (mode_q == PBM_LOOP),
    .len         (pb_len),
    .mem_re      (mem.mem_re),
    .mem_raddr   (mem.mem_raddr),
    .mem_rdata   (mem.mem_rdata),
    .pb_vld      (pb_vld),
    .pb_data     (pb_data),
    .last_issued (last_issued)
  );

  assign mem.mem_we    = wr_fire;
  assign mem.mem_waddr = wr_ptr;
  assign mem.mem_wdata = wr_fire ? mon_data : '0;

  assign pb_done    = pb_done_q;
  assign frozen     = (state == ST_FROZEN);
  assign wrapped    = wrapped_q;
  assign last_waddr = last_q;

`ifdef FM_SB_CAPTURE_CNT_EN
  logic [CNT_W-1:0] cap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           cap_cnt <= '0;
    else if (cap_entry)                cap_cnt <= '0;
    else if (wr_fire && cap_cnt != '1) cap_cnt <= cap_cnt + 1'b1;
  end

  assign capture_cnt = cap_cnt;
`else
  assign capture_cnt = '0;
`endif

endmodule

// File: tb/tb_fm_sb_seq.sv
module tb_fm_sb_seq;
  import fm_sb_pkg::*;

  localparam int unsigned SB_DW  = 64;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  localparam int PH_OFF  = 0;
  localparam int PH_CAP  = 1;
  localparam int PH_POST = 2;
  localparam int PH_FRZ  = 3;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [SB_DW-1:0]  data;
  } wr_exp_t;

  typedef struct packed {
    logic [SB_DW-1:0] data;
    logic             done;
  } pb_exp_t;

  logic              clk;
  logic              rst;
  logic [1:0]        pb_mode;
  logic              freeze_req;
  logic              freeze_clr;
  logic [ADDR_W-1:0] post_trig;
  logic [ADDR_W-1:0] pb_len;
  logic [SB_DW-1:0]  mon_data;
  logic              mon_vld;
  logic [SB_DW-1:0]  pb_data;
  logic              pb_vld;
  logic              pb_done;
  logic              frozen;
  logic              wrapped;
  logic [ADDR_W-1:0] last_waddr;
  logic [CNT_W-1:0]  capture_cnt;

  fm_sb_seq_if #(.SB_DW(SB_DW), .ADDR_W(ADDR_W)) mem_if ();

  fm_sb_seq #(.SB_DW(SB_DW), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pb_mode     (pb_mode),
    .freeze_req  (freeze_req),
    .freeze_clr  (freeze_clr),
    .post_trig   (post_trig),
    .pb_len      (pb_len),
    .mon_data    (mon_data),
    .mon_vld     (mon_vld),
    .mem         (mem_if),
    .pb_data     (pb_data),
    .pb_vld      (pb_vld),
    .pb_done     (pb_done),
    .frozen      (frozen),
    .wrapped     (wrapped),
    .last_waddr  (last_waddr),
    .capture_cnt (capture_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Spy-buffer memory: one write port (plus a bench preload port) and a
  // registered read port.
  logic [SB_DW-1:0]  mem_arr [DEPTH];
  logic              pl_we;
  logic [ADDR_W-1:0] pl_addr;
  logic [SB_DW-1:0]  pl_data;

  always @(posedge clk) begin
    if (pl_we)              mem_arr[pl_addr] <= pl_data;
    else if (mem_if.mem_we) mem_arr[mem_if.mem_waddr] <= mem_if.mem_wdata;
    if (mem_if.mem_re)      mem_if.mem_rdata <= mem_arr[mem_if.mem_raddr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard queues filled by the stimulus-side model.
  wr_exp_t exp_wr[$];
  pb_exp_t exp_pb[$];

  logic    prev_re = 1'b0;
  wr_exp_t mw;
  pb_exp_t mp;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_if.mem_we) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected actual addr=%0d data=%h required no write",
                   mem_if.mem_waddr, mem_if.mem_wdata);
        end else begin
          mw = exp_wr.pop_front();
          chk("wr_addr", 64'(mem_if.mem_waddr), 64'(mw.addr));
          chk("wr_data", mem_if.mem_wdata, mw.data);
        end
      end
      chk("we_re_excl", 64'(mem_if.mem_we & mem_if.mem_re), 64'd0);
      chk("pb_vld_latency", 64'(pb_vld), 64'(prev_re));
      if (pb_vld) begin
        if (exp_pb.size() == 0) begin
          checks++; errors++;
          $display("FAIL pb_unexpected actual data=%h required no pb_vld", pb_data);
        end else begin
          mp = exp_pb.pop_front();
          chk("pb_data", pb_data, mp.data);
          chk("pb_done", 64'(pb_done), 64'(mp.done));
        end
      end else begin
        chk("pb_done_idle", 64'(pb_done), 64'd0);
      end
    end
    prev_re <= !rst && mem_if.mem_re;
  end

  // Reference model for capture: a pointer, a word count and a phase.
  int          m_phase   = PH_OFF;
  int          m_ptr     = 0;
  int          m_written = 0;
  int          m_remain  = 0;
  logic [63:0] img [DEPTH];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [63:0] exp_cnt();
`ifdef FM_SB_CAPTURE_CNT_EN
    return 64'(m_written);
`else
    return 64'd0;
`endif
  endfunction

  task automatic cap_cycle(input logic vld, input logic [63:0] d, input logic frz);
    mon_vld    = vld;
    mon_data   = d;
    freeze_req = frz;
    if (vld && (m_phase == PH_CAP || m_phase == PH_POST)) begin
      exp_wr.push_back('{addr: ADDR_W'(m_ptr % DEPTH), data: d});
      m_ptr++;
      m_written++;
      if (m_phase == PH_POST) begin
        m_remain--;
        if (m_remain == 0) m_phase = PH_FRZ;
      end
    end
    if (frz && m_phase == PH_CAP) begin
      if (post_trig == 0) m_phase = PH_FRZ;
      else begin
        m_phase  = PH_POST;
        m_remain = int'(post_trig);
      end
    end
    step();
    mon_vld    = 1'b0;
    freeze_req = 1'b0;
    mon_data   = rnd64();
  endtask

  task automatic start_capture(input int pt);
    post_trig = ADDR_W'(pt);
    pb_mode   = MODE_CAPTURE;
    step();
    m_phase   = PH_CAP;
    m_ptr     = 0;
    m_written = 0;
  endtask

  task automatic stop_all();
    m_phase = PH_OFF;
    pb_mode = MODE_STOP;
    step();
    step();
  endtask

  task automatic run_once(input int len);
    pb_len  = ADDR_W'(len);
    pb_mode = MODE_ONCE;
    for (int i = 0; i <= len; i++) exp_pb.push_back('{data: img[i], done: (i == len)});
    step();
    pb_len = ADDR_W'($urandom());
    repeat (len + 4) step();
    chk("once_drained", 64'(exp_pb.size()), 64'd0);
    chk("once_done_re", 64'(mem_if.mem_re), 64'd0);
    stop_all();
  endtask

  task automatic run_loop(input int len, input int n);
    pb_len  = ADDR_W'(len);
    pb_mode = MODE_LOOP;
    for (int i = 0; i < n; i++) exp_pb.push_back('{data: img[i % (len + 1)], done: 1'b0});
    step();
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) pb_mode = MODE_STOP;
      step();
    end
    step();
    step();
    chk("loop_drained", 64'(exp_pb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    logic vld;
    logic frz;
    rst = 1'b1; pb_mode = MODE_STOP; freeze_req = 1'b0; freeze_clr = 1'b0;
    post_trig = '0; pb_len = '0; mon_data = rnd64(); mon_vld = 1'b1;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", 64'(mem_if.mem_we), 64'd0);
    chk("rst_mem_waddr", 64'(mem_if.mem_waddr), 64'd0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 64'd0);
    chk("rst_mem_re", 64'(mem_if.mem_re), 64'd0);
    chk("rst_mem_raddr", 64'(mem_if.mem_raddr), 64'd0);
    chk("rst_pb_data", pb_data, 64'd0);
    chk("rst_pb_vld", 64'(pb_vld), 64'd0);
    chk("rst_pb_done", 64'(pb_done), 64'd0);
    chk("rst_frozen", 64'(frozen), 64'd0);
    chk("rst_wrapped", 64'(wrapped), 64'd0);
    chk("rst_last_waddr", 64'(last_waddr), 64'd0);
    chk("rst_capture_cnt", 64'(capture_cnt), 64'd0);
    mon_vld = 1'b0;
    rst = 1'b0;
    step();

    // 20 words through a 16-deep buffer: wraps, oldest four overwritten.
    start_capture(0);
    for (int i = 0; i < 20; i++) cap_cycle(1'b1, 64'(i), 1'b0);
    chk("a_wrapped", 64'(wrapped), 64'd1);
    chk("a_last_waddr", 64'(last_waddr), 64'((m_ptr - 1) % DEPTH));
    for (int a = 0; a < 4; a++) chk("a_mem", mem_arr[a], 64'(16 + a));
    chk("a_capture_cnt", 64'(capture_cnt), exp_cnt());
    stop_all();

    // Trigger on word 7 with post_trig 5; a second trigger is ignored.
    start_capture(5);
    chk("b_wrapped_clr", 64'(wrapped), 64'd0);
    v = 0;
    while (v < 18) begin
      vld = ($urandom_range(0, 3) != 0);
      frz = vld && (v == 7 || v == 9);
      cap_cycle(vld, rnd64(), frz);
      if (vld) v++;
    end
    chk("b_frozen", 64'(frozen), 64'(m_phase == PH_FRZ));
    chk("b_last_waddr", 64'(last_waddr), 64'd12);
    chk("b_written", 64'(m_written), 64'd13);
    chk("b_capture_cnt", 64'(capture_cnt), exp_cnt());
    for (int i = 0; i < 3; i++) cap_cycle(1'b1, rnd64(), 1'b0);
    chk("b_frozen_hold", 64'(frozen), 64'd1);
    freeze_clr = 1'b1;
    pb_mode    = MODE_STOP;
    m_phase    = PH_OFF;
    step();
    freeze_clr = 1'b0;
    chk("b_clr_stop", 64'(frozen), 64'd0);
    step();

    // Zero post-trigger depth: the trigger word is the last one written.
    start_capture(0);
    for (int i = 0; i < 4; i++) cap_cycle(1'b1, rnd64(), (i == 3));
    chk("c_frozen", 64'(frozen), 64'd1);
    for (int i = 0; i < 3; i++) cap_cycle(1'b1, rnd64(), 1'b0);
    chk("c_last_waddr", 64'(last_waddr), 64'd3);
    freeze_clr = 1'b1;
    step();
    freeze_clr = 1'b0;
    chk("c_clr", 64'(frozen), 64'd0);
    stop_all();

    // Preload the memory for playback.
    for (int a = 0; a < int'(DEPTH); a++) begin
      img[a]  = (a < 4) ? 64'(10 + a) : rnd64();
      pl_we   = 1'b1;
      pl_addr = ADDR_W'(a);
      pl_data = img[a];
      step();
    end
    pl_we = 1'b0;
    step();

    run_once(3);
    run_loop(1, 5);
    run_once(int'($urandom_range(0, DEPTH - 1)));
    run_loop(int'($urandom_range(0, 6)), int'($urandom_range(1, 20)));
    run_loop(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 20)));
    run_once(0);

    // Reset while in POST_TRIG, then capture again from address 0.
    start_capture(5);
    cap_cycle(1'b1, rnd64(), 1'b0);
    cap_cycle(1'b1, rnd64(), 1'b1);
    cap_cycle(1'b1, rnd64(), 1'b0);
    rst = 1'b1;
    #1;
    chk("f_async_last_waddr", 64'(last_waddr), 64'd0);
    chk("f_async_cnt", 64'(capture_cnt), 64'd0);
    chk("f_async_waddr", 64'(mem_if.mem_waddr), 64'd0);
    m_phase = PH_OFF;
    step();
    step();
    rst = 1'b0;
    step();
    m_phase = PH_CAP; m_ptr = 0; m_written = 0;
    cap_cycle(1'b1, rnd64(), 1'b0);
    chk("f_cnt_first", 64'(capture_cnt), exp_cnt());
    cap_cycle(1'b1, rnd64(), 1'b0);
    cap_cycle(1'b1, rnd64(), 1'b0);
    chk("f_last_waddr", 64'(last_waddr), 64'd2);
    chk("f_cnt", 64'(capture_cnt), exp_cnt());
    stop_all();

    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("pb_queue_empty", 64'(exp_pb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fm_sb_seq.md
Name: fm_sb_seq

Overview:
- Per-spy-buffer sequencer for the fast-monitoring (FM) subsystem.
- Drives the write and read ports of one spy-buffer memory:
  - circular capture of a monitored datapath bus;
  - freeze on trigger, after a programmable post-trigger depth;
  - playback of stored words, once or looped, into the datapath.
- One instance sits between each monitored/injected bus and its SB_MEM. Mode and length come from the FM control registers.

Parameters:
- SB_DW, 64, stored word width; equals the padded spy-buffer data width from the FM package.
- ADDR_W, 10, memory address width; depth = 2**ADDR_W.
- CNT_W, 32, capture-counter width (axi_dw).

Ports:
- clk, in, 1, single clock for the block (memory and datapath domain).
- rst, in, 1, asynchronous, active-high reset.
- pb_mode, in, 2, 00 STOP, 01 CAPTURE, 10 PB_ONCE, 11 PB_LOOP.
- freeze_req, in, 1, single-cycle trigger pulse.
- freeze_clr, in, 1, single-cycle pulse; leaves FROZEN.
- post_trig, in, ADDR_W, number of words still written after the trigger.
- pb_len, in, ADDR_W, playback length minus 1 (words 0..pb_len).
- mon_data, in, SB_DW, monitored bus data.
- mon_vld, in, 1, monitored bus valid.
- mem_we, out, 1, memory write enable.
- mem_waddr, out, ADDR_W, memory write address.
- mem_wdata, out, SB_DW, memory write data.
- mem_re, out, 1, memory read enable.
- mem_raddr, out, ADDR_W, memory read address.
- mem_rdata, in, SB_DW, memory read data; registered, 1-cycle latency.
- pb_data, out, SB_DW, playback data.
- pb_vld, out, 1, playback valid.
- pb_done, out, 1, single-cycle pulse when PB_ONCE finishes.
- frozen, out, 1, high while in FROZEN.
- wrapped, out, 1, the write pointer has wrapped at least once since the last CAPTURE entry.
- last_waddr, out, ADDR_W, address of the last word written.
- capture_cnt, out, CNT_W, words captured (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; write pointer 0; read pointer 0.
- States: IDLE, CAPTURE, POST_TRIG, FROZEN, PLAYBACK, PB_DONE.
- pb_mode==STOP moves every state to IDLE on the next edge; this has priority over all other transitions.
- IDLE:
  - mode CAPTURE → CAPTURE; write pointer cleared, wrapped cleared.
  - mode PB_ONCE or PB_LOOP → PLAYBACK; read pointer cleared.
- Mode change between non-STOP modes: the current state is left via IDLE, one cycle minimum.
- CAPTURE:
  - mem_we = mon_vld; mem_wdata = mon_data; mem_waddr = write pointer.
  - Write pointer increments per write, modulo 2**ADDR_W. Wrap 2**ADDR_W-1 → 0 sets wrapped.
  - last_waddr updates on every write.
  - freeze_req with post_trig==0 → FROZEN. A word valid in the same cycle is still written.
  - freeze_req with post_trig>0 → POST_TRIG; counter loaded with post_trig.
- POST_TRIG:
  - Writes continue as in CAPTURE; the counter decrements per written word.
  - A write that takes the counter 1→0 is the last one; next state FROZEN.
  - Further freeze_req pulses are ignored.
- FROZEN:
  - mem_we held 0; frozen=1; pointers, wrapped and last_waddr held.
  - freeze_clr → IDLE. When freeze_clr coincides with STOP, the result is IDLE.
- PLAYBACK:
  - mem_re=1 each cycle; mem_raddr = read pointer.
  - pb_vld/pb_data follow mem_re/mem_rdata with exactly 1 cycle of latency.
  - Read pointer 0..pb_len.
  - PB_LOOP: after pb_len the pointer returns to 0 with no gap cycle.
  - PB_ONCE: after issuing pb_len, go to PB_DONE. The last pb_vld appears in the PB_DONE entry cycle, together with pb_done=1 for that cycle.
  - pb_len is sampled on PLAYBACK entry; later changes are ignored until the next entry.
  - Leaving via STOP: a read already issued still produces its single pb_vld cycle.
- PB_DONE: idle outputs; exit only via STOP.
- capture/playback are exclusive: mem_we and mem_re are never both 1.
- Reset mid-operation: immediate return to the reset values above; the memory contents are not touched.

Optional Feature:
- Macro: FM_SB_CAPTURE_CNT_EN.
- Defined:
  - capture_cnt counts every mem_we.
  - It clears on entry to CAPTURE and saturates at 2**CNT_W-1.
- Undefined: capture_cnt is tied to 0 and no counter logic is built. The port list is identical in both cases.

Decomposition:
- fm_sb_pkg gains:
  - pb_mode enum (width pb_mode_width): STOP, CAPTURE, PB_ONCE, PB_LOOP;
  - the sb_seq_state_t typedef;
  - constants for the mode encodings.
- One sub-module, fm_sb_rd_seq:
  - read-pointer generator plus the 1-cycle valid/data alignment;
  - inputs start/loop/len; outputs mem_re, mem_raddr, pb_vld, pb_data, last_issued.

Test Plan:
- ADDR_W=4, CAPTURE, 20 consecutive mon_vld words with data=index → wrapped=1; last_waddr=3; memory addresses 0..3 hold 16..19.
- CAPTURE, post_trig=5, freeze_req on word 7, then 10 more valid words → exactly words 8..12 written; frozen=1; last_waddr=12; mem_we=0 afterwards.
- post_trig=0, freeze_req with mon_vld=1 on word 3 → word 3 written; frozen=1 the next cycle.
- PB_ONCE, pb_len=3, memory preloaded 0xA,0xB,0xC,0xD → pb_vld for 4 consecutive cycles, 1 cycle after mem_re; data A..D; pb_done coincides with D.
- PB_LOOP, pb_len=1; STOP after 5 reads → pb_data A,B,A,B,A with no gaps; pb_vld deasserts 1 cycle after the last mem_re.
- Reset asserted in POST_TRIG, then released, then CAPTURE → write pointer restarts at 0; capture_cnt counts from 1 with the macro defined and stays 0 without it.
